// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing for the stopwatch button controller.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_LAP     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RUNNING = ST_RUNNING,
    PAUSED  = ST_PAUSED,
    LAP     = ST_LAP
  } state_e;

  localparam int DEFAULT_DEBOUNCE_MS   = 20;
  localparam int DEFAULT_LONG_PRESS_MS = 1000;
  localparam int DEFAULT_CNT_W         = 10;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw push-button.
// Emits the filtered level and registered one-cycle press/release pulses.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic clk_1khz,
  input  logic reset_in,
  input  logic btn_raw,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    cnt_d       = '0;
    press_d     = level_q & ~level_dly_q;
    release_d   = ~level_q & level_dly_q;
    // Any matching sample restarts the count, so only an unbroken run flips the level.
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_W'(DEBOUNCE_MS - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (reset_in) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: debounced buttons, lap/reset hold timing and the
// IDLE/RUNNING/PAUSED/LAP state machine driving run, clear and freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS   = DEFAULT_DEBOUNCE_MS,
  parameter int LONG_PRESS_MS = DEFAULT_LONG_PRESS_MS,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic       clk_1khz,
  input  logic       reset_in,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       run,
  output logic       clear,
  output logic       freeze,
  output logic [1:0] state_o
);

  // Index 0 is start/stop, index 1 is lap/reset.
  logic [1:0] btn_raw, lvl, prs, rel;
  logic       unused_pulses;

  assign btn_raw = {btn_lap_reset, btn_start_stop};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .CNT_W      (CNT_W)
      ) u_deb (
        .clk_1khz (clk_1khz),
        .reset_in (reset_in),
        .btn_raw  (btn_raw[gi]),
        .level_o  (lvl[gi]),
        .press_o  (prs[gi]),
        .release_o(rel[gi])
      );
    end
  endgenerate

  assign unused_pulses = ^{lvl[0], rel[0], prs[1]};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             consumed_q, consumed_d;
  logic             long_q, long_d;
  logic             short_evt, start_evt;
  logic             run_q, run_d;
  logic             freeze_q, freeze_d;
  logic             clear_q, clear_d;

  assign start_evt = prs[0];

  always_comb begin
    hold_d     = hold_q;
    consumed_d = consumed_q;
    long_d     = 1'b0;
    short_evt  = rel[1] & ~consumed_q;
    if (lvl[1]) begin
      if (hold_q < CNT_W'(LONG_PRESS_MS)) begin
        hold_d = hold_q + CNT_W'(1);
      end
    end else begin
      hold_d = '0;
    end
    // A press that already fired the long event must not also act on release.
    if (rel[1]) begin
      consumed_d = 1'b0;
    end else if ((hold_q == CNT_W'(LONG_PRESS_MS)) && !consumed_q) begin
      long_d     = 1'b1;
      consumed_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    if (long_q) begin
      state_d = IDLE;
      clear_d = 1'b1;
    end else if (start_evt) begin
      case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        LAP:     state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end else if (short_evt) begin
      case (state_q)
        IDLE:    clear_d = 1'b1;
        RUNNING: state_d = LAP;
        LAP:     state_d = RUNNING;
        PAUSED: begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    run_d    = (state_d == RUNNING) || (state_d == LAP);
    freeze_d = (state_d == LAP);
  end

  always_ff @(posedge clk_1khz) begin
    if (reset_in) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      consumed_q <= 1'b0;
      long_q     <= 1'b0;
      run_q      <= 1'b0;
      freeze_q   <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      consumed_q <= consumed_d;
      long_q     <= long_d;
      run_q      <= run_d;
      freeze_q   <= freeze_d;
      clear_q    <= clear_d;
    end
  end

  assign run     = run_q;
  assign freeze  = freeze_q;
  assign clear   = clear_q;
  assign state_o = state_q;

endmodule
